// File: rtl/lsu_multicycle.sv
// Multi-cycle load/store unit: decodes a 6-bit load/store op, drives a handshaked
// data-memory port (optionally splitting word-crossing accesses) and returns extended load data.
module lsu_multicycle #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [XLEN/8-1:0]     mem_we,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic [2:0]            o_dbg_state
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int SUMW  = OFFW + 2;
  localparam int W2B   = 2 * BYTES;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC1  = 3'd1,
    WAIT1 = 3'd2,
    ACC2  = 3'd3,
    WAIT2 = 3'd4,
    RESP  = 3'd5
  } state_t;

  function automatic logic f_illegal(input logic [5:0] op);
    logic legal;
    legal = 1'b0;
    if (op[5:3] == 3'b010)      legal = (op[2:0] != 3'b111);
    else if (op[5:3] == 3'b110) legal = (op[2] == 1'b0);
    if ((op[1:0] == 2'b11) && (XLEN == 32)) legal = 1'b0;
    return !legal;
  endfunction

  function automatic logic f_split(input logic [1:0] sz, input logic [OFFW-1:0] off);
    logic [SUMW-1:0] n;
    n = SUMW'(1) << sz;
    return ({2'b00, off} + n) > SUMW'(BYTES);
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [5:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rd_lo;
  logic [XLEN-1:0]   r_rd_hi;
  logic              r_err;

  logic              w_acc_err;
  logic [OFFW-1:0]   w_off;
  logic              w_split;
  logic              w_store;
  logic [W2B-1:0]    w_mask;
  logic [W2B-1:0]    w_wide_we;
  logic [2*XLEN-1:0] w_wide_wd;
  logic [XLEN-1:0]   w_wide_rd;
  logic [XLEN-1:0]   w_ld_data;
  logic [ADDR_W-1:0] w_base;

  // Errors are resolved at accept time so they respond without touching memory.
  assign w_acc_err = f_illegal(req_op) |
                     (f_split(req_op[1:0], req_addr[OFFW-1:0]) & !MISALIGN_SPLIT);

  assign w_off     = r_addr[OFFW-1:0];
  assign w_split   = f_split(r_op[1:0], w_off);
  assign w_store   = r_op[5];
  assign w_base    = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign w_wide_we = w_mask << w_off;
  assign w_wide_wd = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_wide_rd = XLEN'({r_rd_hi, r_rd_lo} >> {w_off, 3'b000});

  always_comb begin
    w_mask = '0;
    unique case (r_op[1:0])
      2'b00:   w_mask = W2B'(1);
      2'b01:   w_mask = W2B'(3);
      2'b10:   w_mask = W2B'(15);
      default: w_mask = W2B'(255);
    endcase
  end

  always_comb begin
    w_ld_data = '0;
    unique case (r_op[1:0])
      2'b00:   w_ld_data = r_op[2] ? XLEN'(w_wide_rd[7:0])  : XLEN'($signed(w_wide_rd[7:0]));
      2'b01:   w_ld_data = r_op[2] ? XLEN'(w_wide_rd[15:0]) : XLEN'($signed(w_wide_rd[15:0]));
      2'b10:   w_ld_data = r_op[2] ? XLEN'(w_wide_rd[31:0]) : XLEN'($signed(w_wide_rd[31:0]));
      default: w_ld_data = w_wide_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd_lo <= '0;
      r_rd_hi <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (req_valid && req_ready) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rd_hi <= '0;
        r_err   <= w_acc_err;
      end
      if ((r_state == WAIT1) && mem_rvalid) r_rd_lo <= mem_rdata;
      if ((r_state == WAIT2) && mem_rvalid) r_rd_hi <= mem_rdata;
    end
  end

  // Both ports use valid/ready: a transfer happens on a clock edge where valid and ready
  // are both high; a raised valid and its payload hold steady until that edge.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid)  w_next = w_acc_err ? RESP : ACC1;
      ACC1:    if (mem_ready)  w_next = !w_store ? WAIT1 : (w_split ? ACC2 : RESP);
      WAIT1:   if (mem_rvalid) w_next = w_split ? ACC2 : RESP;
      ACC2:    if (mem_ready)  w_next = w_store ? RESP : WAIT2;
      WAIT2:   if (mem_rvalid) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (r_state == IDLE);
    resp_valid  = (r_state == RESP);
    resp_err    = resp_valid & r_err;
    resp_rdata  = (resp_valid && !r_err && !w_store) ? w_ld_data : '0;
    mem_valid   = (r_state == ACC1) || (r_state == ACC2);
    mem_addr    = '0;
    mem_we      = '0;
    mem_wdata   = '0;
    o_dbg_state = r_state;
    if (r_state == ACC1) begin
      mem_addr = w_base;
      if (w_store) begin
        mem_we    = w_wide_we[BYTES-1:0];
        mem_wdata = w_wide_wd[XLEN-1:0];
      end
    end else if (r_state == ACC2) begin
      mem_addr = w_base + ADDR_W'(BYTES);
      if (w_store) begin
        mem_we    = w_wide_we[W2B-1:BYTES];
        mem_wdata = w_wide_wd[2*XLEN-1:XLEN];
      end
    end
  end

endmodule

// File: tb/tb_lsu_multicycle.sv
// Bench for lsu_multicycle: three instances (32-bit split, 32-bit no-split, 64-bit) share one
// stimulus/memory model; a byte-wise reference model feeds response and access scoreboards.
module tb_lsu_multicycle;
  localparam logic [5:0] OP_LB = 6'b010000, OP_LH = 6'b010001, OP_LW = 6'b010010;
  localparam logic [5:0] OP_LD = 6'b010011, OP_LHU = 6'b010101;
  localparam logic [5:0] OP_SB = 6'b110000, OP_SW = 6'b110010;

  logic        clk, rst_n;
  logic        req_valid;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;
  int          sel, cyc, n_checks, n_errors, ready_wait, rvalid_wait;

  logic [63:0] mem_words [logic [31:0]];
  logic [96:0] exp_q [$];
  logic [103:0] acc_q [$];
  logic [5:0]  op_tab [11];

  logic        rv0, rv1, rv2;
  logic        d0_req_ready, d0_resp_valid, d0_resp_err, d0_mem_valid;
  logic [31:0] d0_resp_rdata, d0_mem_addr, d0_mem_wdata;
  logic [3:0]  d0_mem_we;
  logic [2:0]  d0_state;
  logic        d1_req_ready, d1_resp_valid, d1_resp_err, d1_mem_valid;
  logic [31:0] d1_resp_rdata, d1_mem_addr, d1_mem_wdata;
  logic [3:0]  d1_mem_we;
  logic [2:0]  d1_state;
  logic        d2_req_ready, d2_resp_valid, d2_resp_err, d2_mem_valid;
  logic [63:0] d2_resp_rdata, d2_mem_wdata;
  logic [31:0] d2_mem_addr;
  logic [7:0]  d2_mem_we;
  logic [2:0]  d2_state;

  logic        v_req_ready, v_resp_valid, v_resp_err, v_mem_valid;
  logic [63:0] v_resp_rdata, v_mem_wdata;
  logic [31:0] v_mem_addr;
  logic [7:0]  v_mem_we;
  logic [2:0]  v_state;

  assign rv0 = req_valid && (sel == 0);
  assign rv1 = req_valid && (sel == 1);
  assign rv2 = req_valid && (sel == 2);

  lsu_multicycle #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(d0_req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .resp_valid(d0_resp_valid),
    .resp_rdata(d0_resp_rdata), .resp_err(d0_resp_err), .mem_valid(d0_mem_valid),
    .mem_ready(mem_ready), .mem_addr(d0_mem_addr), .mem_we(d0_mem_we), .mem_wdata(d0_mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]), .o_dbg_state(d0_state));

  lsu_multicycle #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(d1_req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .resp_valid(d1_resp_valid),
    .resp_rdata(d1_resp_rdata), .resp_err(d1_resp_err), .mem_valid(d1_mem_valid),
    .mem_ready(mem_ready), .mem_addr(d1_mem_addr), .mem_we(d1_mem_we), .mem_wdata(d1_mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]), .o_dbg_state(d1_state));

  lsu_multicycle #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_ready(d2_req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(d2_resp_valid),
    .resp_rdata(d2_resp_rdata), .resp_err(d2_resp_err), .mem_valid(d2_mem_valid),
    .mem_ready(mem_ready), .mem_addr(d2_mem_addr), .mem_we(d2_mem_we), .mem_wdata(d2_mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .o_dbg_state(d2_state));

  always_comb begin
    v_req_ready  = d0_req_ready;
    v_resp_valid = d0_resp_valid;
    v_resp_err   = d0_resp_err;
    v_resp_rdata = 64'(d0_resp_rdata);
    v_mem_valid  = d0_mem_valid;
    v_mem_addr   = d0_mem_addr;
    v_mem_we     = 8'(d0_mem_we);
    v_mem_wdata  = 64'(d0_mem_wdata);
    v_state      = d0_state;
    if (sel == 1) begin
      v_req_ready  = d1_req_ready;
      v_resp_valid = d1_resp_valid;
      v_resp_err   = d1_resp_err;
      v_resp_rdata = 64'(d1_resp_rdata);
      v_mem_valid  = d1_mem_valid;
      v_mem_addr   = d1_mem_addr;
      v_mem_we     = 8'(d1_mem_we);
      v_mem_wdata  = 64'(d1_mem_wdata);
      v_state      = d1_state;
    end else if (sel == 2) begin
      v_req_ready  = d2_req_ready;
      v_resp_valid = d2_resp_valid;
      v_resp_err   = d2_resp_err;
      v_resp_rdata = d2_resp_rdata;
      v_mem_valid  = d2_mem_valid;
      v_mem_addr   = d2_mem_addr;
      v_mem_we     = d2_mem_we;
      v_mem_wdata  = d2_mem_wdata;
      v_state      = d2_state;
    end
  end

  // clock / cycle counter / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_at(input logic [31:0] k);
    return mem_words.exists(k) ? mem_words[k] : 64'd0;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a, input int b);
    logic [63:0] w;
    w = word_at(a & ~(32'(b - 1)));
    return w[8 * int'(a % 32'(b)) +: 8];
  endfunction

  // Driver: offers one request, waits for acceptance and pushes the model's expectations.
  task automatic do_req(input logic [5:0] op, input logic [31:0] addr, input logic [63:0] wdata);
    int b, n, off, lat, k;
    bit legal, split, err, st;
    logic [63:0] rd, lo_wd, hi_wd;
    logic [7:0]  lo_we, hi_we;
    logic [31:0] base;
    b   = (sel == 2) ? 8 : 4;
    n   = 1 << op[1:0];
    off = int'(addr % 32'(b));
    st  = op[5];
    case (op)
      6'b010000, 6'b010001, 6'b010010, 6'b010100, 6'b010101, 6'b010110,
      6'b110000, 6'b110001, 6'b110010: legal = 1'b1;
      6'b010011, 6'b110011:            legal = (b == 8);
      default:                         legal = 1'b0;
    endcase
    split = (off + n) > b;
    err   = !legal || (split && (sel == 1));
    base  = addr & ~(32'(b - 1));
    rd = '0; lo_wd = '0; hi_wd = '0; lo_we = '0; hi_we = '0;
    if (!err && st) begin
      for (int j = 0; j < b; j++) begin
        int lane;
        lane = off + j;
        if (lane < b) begin
          lo_wd[8*lane +: 8] = wdata[8*j +: 8];
          if (j < n) lo_we[lane] = 1'b1;
        end else begin
          hi_wd[8*(lane-b) +: 8] = wdata[8*j +: 8];
          if (j < n) hi_we[lane-b] = 1'b1;
        end
      end
    end else if (!err) begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = mem_byte(addr + 32'(i), b);
      if (!op[2] && rd[8*n-1]) rd = rd | (~64'd0 << (8 * n));
      if (b == 4) rd[63:32] = '0;
    end
    if (err) lat = 1;
    else lat = (st ? (split ? 3 : 2) : (split ? 5 : 3)) + (split ? 2 : 1) * ready_wait;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    k = 0;
    while (!v_req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!v_req_ready) begin
      check_eq("req_ready_timeout", 128'(v_req_ready), 128'(1));
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back({32'(cyc + lat), err, rd});
    if (!err) begin
      acc_q.push_back({base, lo_we, lo_wd});
      if (split) acc_q.push_back({base + 32'(b), hi_we, hi_wd});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_queues", 128'(exp_q.size() + acc_q.size()), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_block(input int n_outer);
    for (int o = 0; o < n_outer; o++) begin
      ready_wait = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++)
        do_req(op_tab[$urandom_range(0, 10)], 32'h400 + 32'($urandom_range(0, 63)),
               {$urandom, $urandom});
      drain();
    end
  endtask

  // Scoreboard: compare each response against the head of exp_q.
  initial begin
    logic [96:0] e;
    forever begin
      @(negedge clk);
      if (v_resp_valid) begin
        if (exp_q.size() == 0) check_eq("resp_unexpected", 128'(v_resp_valid), 128'(0));
        else begin
          e = exp_q.pop_front();
          check_eq("resp_cycle", 128'(cyc), 128'(e[96:65]));
          check_eq("resp_err", 128'(v_resp_err), 128'(e[64]));
          check_eq("resp_rdata", 128'(v_resp_rdata), 128'(e[63:0]));
        end
      end
    end
  end

  // Memory responder: stalls ready_wait cycles per access, returns read data after rvalid_wait.
  initial begin
    logic [103:0] a;
    logic [63:0]  rd_data;
    logic [31:0]  acc_addr;
    bit           acc_rd, rd_pend;
    int           wait_cnt, rd_cnt;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rd_pend = 1'b0; wait_cnt = 0; rd_cnt = 0; acc_rd = 1'b0; acc_addr = '0; rd_data = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (mem_ready) begin
        mem_ready = 1'b0;
        if (acc_rd) begin
          rd_pend = 1'b1;
          rd_cnt  = rvalid_wait;
          rd_data = word_at(acc_addr);
        end
      end
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_data;
          rd_pend    = 1'b0;
        end else rd_cnt--;
      end
      if (v_mem_valid) begin
        if (acc_q.size() == 0) check_eq("mem_valid_unexpected", 128'(v_mem_valid), 128'(0));
        else begin
          a = acc_q[0];
          check_eq("mem_addr", 128'(v_mem_addr), 128'(a[103:72]));
          check_eq("mem_we", 128'(v_mem_we), 128'(a[71:64]));
          check_eq("mem_wdata", 128'(v_mem_wdata), 128'(a[63:0]));
          if (wait_cnt >= ready_wait) begin
            mem_ready = 1'b1;
            acc_rd    = (v_mem_we == 8'd0);
            acc_addr  = v_mem_addr;
            wait_cnt  = 0;
            void'(acc_q.pop_front());
          end else wait_cnt++;
        end
      end else begin
        check_eq("mem_we_idle", 128'(v_mem_we), 128'(0));
        check_eq("mem_wdata_idle", 128'(v_mem_wdata), 128'(0));
      end
    end
  end

  // Main sequence
  initial begin
    int k;
    n_checks = 0; n_errors = 0; cyc = 0; sel = 0; ready_wait = 0; rvalid_wait = 0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    op_tab = '{6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b010100, 6'b010101,
               6'b010110, 6'b110000, 6'b110001, 6'b110010, 6'b110011};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 128'(v_req_ready), 128'(1));
    check_eq("rst_resp_valid", 128'(v_resp_valid), 128'(0));
    check_eq("rst_resp_rdata", 128'(v_resp_rdata), 128'(0));
    check_eq("rst_resp_err", 128'(v_resp_err), 128'(0));
    check_eq("rst_mem_valid", 128'(v_mem_valid), 128'(0));
    check_eq("rst_mem_addr", 128'(v_mem_addr), 128'(0));
    check_eq("rst_state", 128'(v_state), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // XLEN=32, split enabled
    mem_words[32'h100] = 64'hDEADBEEF;
    do_req(OP_LW, 32'h100, 64'd0);
    drain();
    mem_words[32'h100] = 64'h11223344;
    mem_words[32'h104] = 64'h55667788;
    do_req(OP_LH, 32'h103, 64'd0);
    do_req(OP_LHU, 32'h103, 64'd0);
    do_req(OP_SW, 32'h006, 64'hAABBCCDD);
    do_req(OP_LB, 32'h101, 64'd0);
    drain();
    ready_wait = 5;
    do_req(OP_SB, 32'h203, 64'h5A);
    drain();
    ready_wait = 0;
    for (int a = 32'h400; a < 32'h450; a += 4) mem_words[32'(a)] = {$urandom, $urandom};
    rand_block(6);

    // XLEN=32, misalignment reported as error
    sel = 1;
    ready_wait = 0;
    do_req(OP_LW, 32'h101, 64'd0);
    do_req(6'b001000, 32'h100, 64'd0);
    do_req(OP_LW, 32'h104, 64'd0);
    drain();

    // XLEN=64
    sel = 2;
    ready_wait = 0;
    mem_words[32'h10] = 64'h0123456789ABCDEF;
    do_req(OP_LD, 32'h10, 64'd0);
    drain();
    rand_block(6);

    // reset during WAIT1, stray rvalid afterwards, then a clean load
    ready_wait = 0;
    rvalid_wait = 3;
    mem_words[32'h20] = 64'hCAFEF00D12345678;
    do_req(OP_LW, 32'h20, 64'd0);
    k = 0;
    while (v_state != 3'd2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("wait1_reached", 128'(v_state), 128'(2));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("abort_state", 128'(v_state), 128'(0));
    check_eq("abort_mem_valid", 128'(v_mem_valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("stray_rvalid_state", 128'(v_state), 128'(0));
    rvalid_wait = 0;
    do_req(OP_LW, 32'h24, 64'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
